// File: rtl/trap_unit.sv
// Commit-stage trap unit: detects exceptions/timer interrupts, drains the pipe,
// then strobes a one-cycle trap commit with mcause/mtval/mepc. Also owns mtime/mtimecmp.
package trap_pkg;
    typedef enum logic [3:0] {
        MEM_NONE = 4'h0,
        MEM_LB   = 4'h8,
        MEM_LH   = 4'h9,
        MEM_LW   = 4'hA,
        MEM_LBU  = 4'hB,
        MEM_LHU  = 4'hC,
        MEM_SB   = 4'hD,
        MEM_SH   = 4'hE,
        MEM_SW   = 4'hF
    } mem_inst_type_t;

    localparam logic [31:0] M_INSTR_MISALIGN = 32'd0;
    localparam logic [31:0] M_INSTR_AFAULT   = 32'd1;
    localparam logic [31:0] M_LOAD_MISALIGN  = 32'd4;
    localparam logic [31:0] M_LOAD_AFAULT    = 32'd5;
    localparam logic [31:0] M_STORE_MISALIGN = 32'd6;
    localparam logic [31:0] M_STORE_AFAULT   = 32'd7;
endpackage

module trap_unit
    import trap_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int N_MEM_REGIONS = 2,
    parameter logic [XLEN-1:0] PC_BASE  = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_LIMIT = 32'h0000_FFFF,
    parameter logic [N_MEM_REGIONS-1:0][XLEN-1:0] MEM_BASE  = {32'h1000_0000, 32'h2000_0000},
    parameter logic [N_MEM_REGIONS-1:0][XLEN-1:0] MEM_LIMIT = {32'h1000_FFFF, 32'h2000_00FF},
    parameter int FLUSH_CYCLES  = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] data_addr_i,
    input  mem_inst_type_t  mem_inst_type_i,
    input  logic            priv_i,
    input  logic [XLEN-1:0] priv_cause_i,
    input  logic            mstatus_mie_i,
    input  logic            mie_mtie_i,
    input  logic            mtimecmp_we_i,
    input  logic            mtimecmp_hi_i,
    input  logic [XLEN-1:0] mtimecmp_wdata_i,
    output logic            stall_o,
    output logic            flush_o,
    output logic            trap_o,
    output logic [XLEN-1:0] exc_cause_o,
    output logic [XLEN-1:0] trap_info_o,
    output logic [XLEN-1:0] epc_o,
    output logic [63:0]     mtime_o,
    output logic            mtip_o
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt;
    logic [XLEN-1:0] r_cause, r_info, r_epc;
    logic [63:0]     r_mtime, r_mtimecmp;
    logic            r_mtip;

    logic            w_mem_op, w_is_store, w_half, w_word;
    logic            w_pc_ok, w_mem_hit, w_mem_misalign, w_irq;
    logic            w_hit, w_detect;
    logic [XLEN-1:0] w_cause, w_info;

    // Window checks as offset-from-base so a zero base needs no always-true compare.
    assign w_pc_ok = (pc_i - PC_BASE) <= (PC_LIMIT - PC_BASE);

    always_comb begin
        w_mem_hit = 1'b0;
        for (int r = 0; r < N_MEM_REGIONS; r++) begin
            if ((data_addr_i - MEM_BASE[r]) <= (MEM_LIMIT[r] - MEM_BASE[r]))
                w_mem_hit = 1'b1;
        end
    end

    assign w_mem_op       = mem_inst_type_i[3];
    assign w_is_store     = (mem_inst_type_i == MEM_SB) || (mem_inst_type_i == MEM_SH) ||
                            (mem_inst_type_i == MEM_SW);
    assign w_half         = (mem_inst_type_i == MEM_LH) || (mem_inst_type_i == MEM_LHU) ||
                            (mem_inst_type_i == MEM_SH);
    assign w_word         = (mem_inst_type_i == MEM_LW) || (mem_inst_type_i == MEM_SW);
    assign w_mem_misalign = (w_half && data_addr_i[0]) || (w_word && (data_addr_i[1:0] != 2'b00));
    assign w_irq          = r_mtip && mstatus_mie_i && mie_mtie_i;

    always_comb begin
        w_hit   = 1'b1;
        w_cause = '0;
        w_info  = '0;
        if (w_irq) begin
            w_cause = {1'b1, (XLEN-1)'(7)};
        end else if (pc_i[1:0] != 2'b00) begin
            w_cause = XLEN'(M_INSTR_MISALIGN);
            w_info  = pc_i;
        end else if (!w_pc_ok) begin
            w_cause = XLEN'(M_INSTR_AFAULT);
            w_info  = pc_i;
        end else if (w_mem_op && !w_mem_hit) begin
            w_cause = w_is_store ? XLEN'(M_STORE_AFAULT) : XLEN'(M_LOAD_AFAULT);
            w_info  = data_addr_i;
        end else if (priv_i) begin
            w_cause = priv_cause_i;
            w_info  = pc_i;
        end else if (w_mem_op && w_mem_misalign) begin
            w_cause = w_is_store ? XLEN'(M_STORE_MISALIGN) : XLEN'(M_LOAD_MISALIGN);
            w_info  = data_addr_i;
        end else begin
            w_hit   = 1'b0;
        end
    end

    assign w_detect = valid_i && (r_state == S_IDLE) && w_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == S_DRAIN) ? r_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_detect) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_cnt == 4'(FLUSH_CYCLES - 1)) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o = (r_state == S_DRAIN) || (r_state == S_COMMIT);
        flush_o = (r_state == S_DRAIN) && (r_cnt == 4'd0);
        trap_o  = (r_state == S_COMMIT);
    end

    // Trap record stays put until the next detection overwrites it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cause <= '0;
            r_info  <= '0;
            r_epc   <= '0;
        end else if (w_detect) begin
            r_cause <= w_cause;
            r_info  <= w_info;
            r_epc   <= pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_mtip     <= 1'b0;
        end else begin
            r_mtime <= r_mtime + 64'd1;
            r_mtip  <= (r_mtime >= r_mtimecmp);
            if (mtimecmp_we_i) begin
                if (mtimecmp_hi_i) r_mtimecmp[63:32] <= mtimecmp_wdata_i[31:0];
                else               r_mtimecmp[31:0]  <= mtimecmp_wdata_i[31:0];
            end
        end
    end

    assign exc_cause_o = r_cause;
    assign trap_info_o = r_info;
    assign epc_o       = r_epc;
    assign mtime_o     = r_mtime;
    assign mtip_o      = r_mtip;

endmodule

// File: tb/tb_trap_unit.sv
// Scoreboard bench for trap_unit: expected trap records are queued when a
// faulting instruction is driven and compared when trap_o strobes.
module tb_trap_unit;
    import trap_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           valid_i = 1'b0;
    logic [31:0]    pc_i = '0, data_addr_i = '0, priv_cause_i = '0, mtimecmp_wdata_i = '0;
    mem_inst_type_t mem_inst_type_i = MEM_NONE;
    logic           priv_i = 1'b0, mstatus_mie_i = 1'b0, mie_mtie_i = 1'b0;
    logic           mtimecmp_we_i = 1'b0, mtimecmp_hi_i = 1'b0;
    logic           stall_o, flush_o, trap_o, mtip_o;
    logic [31:0]    exc_cause_o, trap_info_o, epc_o;
    logic [63:0]    mtime_o;

    typedef struct { logic [31:0] c; logic [31:0] i; logic [31:0] e; } exp_t;
    exp_t   q[$];
    exp_t   mon_e;
    int     n_chk = 0, n_err = 0, n_trap = 0, n_exp = 0;
    logic [63:0] exp_mtime = '0;

    trap_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
        .data_addr_i(data_addr_i), .mem_inst_type_i(mem_inst_type_i),
        .priv_i(priv_i), .priv_cause_i(priv_cause_i),
        .mstatus_mie_i(mstatus_mie_i), .mie_mtie_i(mie_mtie_i),
        .mtimecmp_we_i(mtimecmp_we_i), .mtimecmp_hi_i(mtimecmp_hi_i),
        .mtimecmp_wdata_i(mtimecmp_wdata_i),
        .stall_o(stall_o), .flush_o(flush_o), .trap_o(trap_o),
        .exc_cause_o(exc_cause_o), .trap_info_o(trap_info_o), .epc_o(epc_o),
        .mtime_o(mtime_o), .mtip_o(mtip_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference timer: free-running count cleared by reset.
    always @(posedge clk_i) exp_mtime <= rst_i ? 64'd0 : exp_mtime + 64'd1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (trap_o === 1'b1) begin
            n_trap++;
            if (q.size() == 0) chk("spurious_trap", 64'd1, 64'd0);
            else begin
                mon_e = q.pop_front();
                chk("sb_cause", {32'd0, exc_cause_o}, {32'd0, mon_e.c});
                chk("sb_info",  {32'd0, trap_info_o}, {32'd0, mon_e.i});
                chk("sb_epc",   {32'd0, epc_o},       {32'd0, mon_e.e});
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] c, input logic [31:0] i, input logic [31:0] e);
        exp_t x;
        x.c = c; x.i = i; x.e = e;
        q.push_back(x);
        n_exp++;
    endtask

    // Present one instruction for a single commit edge, then check the reaction.
    task automatic fire(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                        input mem_inst_type_t t, input logic pv, input logic [31:0] pcause,
                        input bit trap, input logic [31:0] ec, input logic [31:0] ei);
        pc_i = pc; data_addr_i = addr; mem_inst_type_i = t; priv_i = pv; priv_cause_i = pcause;
        valid_i = 1'b1;
        if (trap) push(ec, ei, pc);
        step();
        valid_i = 1'b0; mem_inst_type_i = MEM_NONE; priv_i = 1'b0;
        chk({tag, "_flush"}, {63'd0, flush_o}, {63'd0, trap});
        if (trap) begin
            step();
            step();
        end
        chk({tag, "_idle"}, {63'd0, stall_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(); step(); step();
        chk("rst_stall", {63'd0, stall_o}, 64'd0);
        chk("rst_flush", {63'd0, flush_o}, 64'd0);
        chk("rst_trap",  {63'd0, trap_o},  64'd0);
        chk("rst_cause", {32'd0, exc_cause_o}, 64'd0);
        chk("rst_mtime", mtime_o, 64'd0);
        chk("rst_mtip",  {63'd0, mtip_o},  64'd0);
        rst_i = 1'b0;

        // Misaligned PC: flush next cycle, trap two cycles after detect.
        pc_i = 32'h102; valid_i = 1'b1;
        push(M_INSTR_MISALIGN, 32'h102, 32'h102);
        step();
        valid_i = 1'b0;
        chk("t1_flush", {63'd0, flush_o}, 64'd1);
        chk("t1_stall", {63'd0, stall_o}, 64'd1);
        chk("t1_notrap", {63'd0, trap_o}, 64'd0);
        step();
        chk("t1_trap", {63'd0, trap_o}, 64'd1);
        chk("t1_flush2", {63'd0, flush_o}, 64'd0);
        step();
        chk("t1_end", {63'd0, trap_o | stall_o}, 64'd0);
        chk("t1_epc_hold", {32'd0, epc_o}, 64'h102);
        chk("mtime_run", mtime_o, exp_mtime);

        // Data and PC window boundaries.
        fire("lw_oob", 32'h100, 32'h2000_0100, MEM_LW, 1'b0, 32'd0, 1'b1, M_LOAD_AFAULT, 32'h2000_0100);
        fire("lw_ok",  32'h104, 32'h2000_00FC, MEM_LW, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        fire("lw_top", 32'h108, 32'h1000_FFFC, MEM_LW, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        fire("sb_base", 32'h10C, 32'h1000_0000, MEM_SB, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        fire("sb_oob", 32'h110, 32'h1001_0000, MEM_SB, 1'b0, 32'd0, 1'b1, M_STORE_AFAULT, 32'h1001_0000);
        fire("sb_low", 32'h114, 32'h0FFF_FFFF, MEM_SB, 1'b0, 32'd0, 1'b1, M_STORE_AFAULT, 32'h0FFF_FFFF);
        fire("pc_top", 32'h0000_FFFC, 32'd0, MEM_NONE, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        fire("pc_oob", 32'h0001_0000, 32'd0, MEM_NONE, 1'b0, 32'd0, 1'b1, M_INSTR_AFAULT, 32'h0001_0000);

        // Privileged beats misalign; misalign by access size.
        fire("sh_priv", 32'h200, 32'h1000_0003, MEM_SH, 1'b1, 32'h0000_000B, 1'b1, 32'h0000_000B, 32'h200);
        fire("sh_mis",  32'h204, 32'h1000_0003, MEM_SH, 1'b0, 32'd0, 1'b1, M_STORE_MISALIGN, 32'h1000_0003);
        fire("lh_mis",  32'h208, 32'h1000_0001, MEM_LH, 1'b0, 32'd0, 1'b1, M_LOAD_MISALIGN, 32'h1000_0001);
        fire("lbu_ok",  32'h20C, 32'h1000_0003, MEM_LBU, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        fire("lhu_ok",  32'h210, 32'h1000_0002, MEM_LHU, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        fire("sw_mis",  32'h214, 32'h2000_0002, MEM_SW, 1'b0, 32'd0, 1'b1, M_STORE_MISALIGN, 32'h2000_0002);

        // Second fault held under stall is taken only after the unit is idle again.
        pc_i = 32'h106; valid_i = 1'b1;
        push(M_INSTR_MISALIGN, 32'h106, 32'h106);
        step();
        pc_i = 32'h10A;
        push(M_INSTR_MISALIGN, 32'h10A, 32'h10A);
        step();
        chk("hold_stall", {63'd0, stall_o}, 64'd1);
        step();
        chk("hold_idle", {63'd0, stall_o}, 64'd0);
        chk("hold_epc",  {32'd0, epc_o}, 64'h106);
        step();
        valid_i = 1'b0;
        chk("hold_flush2", {63'd0, flush_o}, 64'd1);
        chk("hold_epc2",  {32'd0, epc_o}, 64'h10A);
        step(); step();

        // Reset mid-drain aborts the trap and ignores valid in the reset cycle.
        pc_i = 32'h102; valid_i = 1'b1;
        step();
        chk("rd_drain", {63'd0, stall_o}, 64'd1);
        rst_i = 1'b1; pc_i = 32'h106;
        step();
        chk("rd_outs", {61'd0, stall_o, flush_o, trap_o}, 64'd0);
        chk("rd_regs", {exc_cause_o, trap_info_o | epc_o}, 64'd0);
        chk("rd_mtime", mtime_o, 64'd0);
        step();
        rst_i = 1'b0; valid_i = 1'b0;
        step();
        chk("rd_mtime1", mtime_o, 64'd1);
        chk("rd_nostall", {63'd0, stall_o}, 64'd0);

        // Timer: compare = 20 written at mtime 5; pending appears with mtime 21.
        mstatus_mie_i = 1'b1; mie_mtie_i = 1'b1;
        for (int k = 0; k < 20 && exp_mtime != 64'd5; k++) step();
        chk("tm_at5", mtime_o, 64'd5);
        mtimecmp_we_i = 1'b1; mtimecmp_hi_i = 1'b0; mtimecmp_wdata_i = 32'd20;
        step();
        mtimecmp_hi_i = 1'b1; mtimecmp_wdata_i = 32'd0;
        step();
        mtimecmp_we_i = 1'b0;
        for (int k = 0; k < 40 && exp_mtime != 64'd20; k++) step();
        chk("tm_at20", mtime_o, 64'd20);
        chk("tm_mtip0", {63'd0, mtip_o}, 64'd0);
        step();
        chk("tm_at21", mtime_o, 64'd21);
        chk("tm_mtip1", {63'd0, mtip_o}, 64'd1);
        step(); step(); step();
        chk("tm_noval", {63'd0, stall_o | trap_o}, 64'd0);
        fire("tm_irq", 32'h102, 32'd0, MEM_NONE, 1'b0, 32'd0, 1'b1, 32'h8000_0007, 32'd0);
        mstatus_mie_i = 1'b0;
        fire("tm_mask", 32'h102, 32'd0, MEM_NONE, 1'b0, 32'd0, 1'b1, M_INSTR_MISALIGN, 32'h102);

        step(); step();
        chk("q_empty", 64'(q.size()), 64'd0);
        chk("n_trap", 64'(n_trap), 64'(n_exp));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/trap_unit.md
TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, the address/data width.
REQ-002 SHALL have parameter N_MEM_REGIONS, default 2, the number of valid data address windows.
REQ-003 SHALL have parameters PC_BASE/PC_LIMIT, default 32'h0000_0000/32'h0000_FFFF, the inclusive valid PC window.
REQ-004 SHALL have parameters MEM_BASE/MEM_LIMIT, each [N_MEM_REGIONS][XLEN], defaults {32'h1000_0000,32'h2000_0000}/{32'h1000_FFFF,32'h2000_00FF}, the inclusive data windows.
REQ-005 SHALL have parameter FLUSH_CYCLES, default 1 (range 1..15), the pipeline drain length before trap commit.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port rst_i, input, 1, the reset; synchronous, active-high.
REQ-008 SHALL have port valid_i, input, 1, an instruction is at commit.
REQ-009 SHALL have ports pc_i and data_addr_i, input, XLEN each, the commit PC and effective address.
REQ-010 SHALL have port mem_inst_type_i, input, mem_inst_type_t; bit 3 set means a memory op (MEM_LB..MEM_SW).
REQ-011 SHALL have ports priv_i (input, 1) and priv_cause_i (input, XLEN), a privileged-instruction trap request and its cause.
REQ-012 SHALL have ports mstatus_mie_i and mie_mtie_i, input, 1 each, the global and timer interrupt enables.
REQ-013 SHALL have ports mtimecmp_we_i (input, 1), mtimecmp_hi_i (input, 1; 1=upper word) and mtimecmp_wdata_i (input, XLEN).
REQ-014 SHALL have port stall_o, output, 1, hold commit stage.
REQ-015 SHALL have port flush_o, output, 1, kill younger instructions.
REQ-016 SHALL have port trap_o, output, 1, a one-cycle trap commit strobe.
REQ-017 SHALL have ports exc_cause_o, trap_info_o and epc_o, output, XLEN each, the mcause/mtval/mepc values valid while trap_o=1.
REQ-018 SHALL have ports mtime_o (output, 64) and mtip_o (output, 1), the timer value and pending flag.

Function
REQ-019 SHALL evaluate detection only when valid_i=1 and the FSM is IDLE; otherwise no new trap.
REQ-020 SHALL use priority, highest first: timer interrupt (mtip_o & mstatus_mie_i & mie_mtie_i) -> cause 32'h8000_0007, info 0; pc_i[1:0]!=0 -> M_INSTR_MISALIGN, info pc_i; pc_i outside [PC_BASE,PC_LIMIT] -> M_INSTR_AFAULT, info pc_i; memory op with data_addr_i in no region -> M_LOAD_AFAULT (loads) / M_STORE_AFAULT (stores), info data_addr_i; priv_i -> priv_cause_i, info pc_i; misaligned access (H/HU at addr[0]=1; W at addr[1:0]!=0) -> M_LOAD_MISALIGN / M_STORE_MISALIGN, info data_addr_i.
REQ-021 SHALL use unsigned inclusive compares at both window bounds; data address valid if it hits any region.
REQ-022 SHALL capture cause, info and epc=pc_i in registers on detection.
REQ-023 SHALL implement FSM IDLE -> DRAIN on detection; DRAIN holds FLUSH_CYCLES cycles, then -> COMMIT; COMMIT lasts 1 cycle, then -> IDLE.
REQ-024 SHALL assert flush_o in the first DRAIN cycle only.
REQ-025 SHALL assert stall_o in DRAIN and COMMIT.
REQ-026 SHALL assert trap_o in COMMIT only.
REQ-027 SHALL hold exc_cause_o/trap_info_o/epc_o stable from detection until the next detection.
REQ-028 SHALL drop any new request during DRAIN/COMMIT; upstream holds under stall.
REQ-029 SHALL increment the 64-bit mtime by 1 every cycle, wrapping 2^64-1 -> 0.
REQ-030 SHALL write the selected 32-bit half of mtimecmp on mtimecmp_we_i; the other half is unchanged.
REQ-031 SHALL register mtip_o = (mtime >= mtimecmp), unsigned, using pre-write values, so a write affects mtip_o two cycles later.
REQ-032 SHALL raise no interrupt trap while mtip_o=1 without valid_i.

Reset
REQ-033 SHALL, while rst_i=1 at a clock edge, force FSM=IDLE, mtime=0, mtimecmp=all-ones, mtip_o=0, stall_o=flush_o=trap_o=0 and exc_cause_o=trap_info_o=epc_o=0.
REQ-034 SHALL let reset mid-DRAIN/COMMIT abort the trap with no trap_o, and ignore valid_i in the reset cycle.

Verification
REQ-035 Bench SHALL check: valid_i, pc_i=32'h102 -> flush_o next cycle, trap_o 2 cycles after detect (FLUSH_CYCLES=1), cause M_INSTR_MISALIGN, info/epc 32'h102.
REQ-036 Bench SHALL check: MEM_LW, data_addr_i=32'h2000_0100 -> M_LOAD_AFAULT, info 32'h2000_0100; 32'h2000_00FC -> no trap.
REQ-037 Bench SHALL check: MEM_SH, data_addr_i=32'h1000_0003, priv_i=1 -> cause priv_cause_i (priv beats misalign).
REQ-038 Bench SHALL check: write mtimecmp lo=20, hi=0 at mtime=5, enables set -> mtip_o=1 at mtime=21 registered; next valid_i gives cause 32'h8000_0007 over a pending misaligned PC.
REQ-039 Bench SHALL check: rst_i during DRAIN -> no trap_o, all outputs 0, mtime restarts at 0.
REQ-040 Bench SHALL check: second fault held on valid_i during stall -> detected only after IDLE return, one trap_o per fault.
